seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit seven-segment display on the lab board. It holds a 16-bit hex value and routes one nibble at a time through a single shared hex-to-segment decoder, driving the digit anodes in rotation. New values are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new digits. It sits between the core datapath, which posts results via `wrt`, and the board's segment/anode pins.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, 4: cycles at the start of each slot with all anodes off (anti-ghosting); must be ≥1.
- `BLANK_LZ`, 1: 1 = blank leading zeros (digit 0 is never blanked).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wrt` in 1: one-cycle strobe; captures `val`/`dp_in` into the staging register.
- `val` in 16: hex value; nibble *i* is shown on digit *i* (digit 0 is rightmost).
- `dp_in` in 4: decimal point per digit, 1 = lit.
- `seg_n` out 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `dp_n` out 1: decimal point, active-low, registered.
- `an_n` out 4: digit anodes, one-hot active-low, registered.
- `pending` out 1: staged value not yet committed to display.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- Registers: `staged` (16+4 bits), `shadow` (16+4 bits, the displayed value), `pending`, slot counter `cnt` (`$clog2(REFRESH_DIV)` bits), digit index `dig` (2 bits), phase state.
- Phase FSM per slot: BLANK for `cnt` 0..`BLANK_CYC`-1, then DRIVE for `cnt` `BLANK_CYC`..`REFRESH_DIV`-1.
  - BLANK: `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1.
  - DRIVE: `an_n` has bit `dig` low. `seg_n` is decode(`shadow` nibble `dig`), or 7'h7F if the digit is lz-blanked. `dp_n` = ~`shadow.dp[dig]`.
- Slot end (`cnt`==`REFRESH_DIV`-1): `cnt`←0, `dig`←`dig`+1 (3 wraps to 0), phase←BLANK.
- Frame boundary is the slot end with `dig`==3. At this edge:
  - if `pending`: `shadow`←`staged`, `pending`←0;
  - `frame_done`←1 for exactly one cycle.
- `wrt`: `staged`←{`dp_in`,`val`}, `pending`←1.
  - `wrt` on the frame-boundary cycle: the boundary commits the old `staged`; the new value is captured and `pending` stays 1. It commits at the next boundary.
  - Repeated `wrt` before a boundary: the last one wins.
- Leading-zero blanking (`BLANK_LZ`=1): digit *i*>0 is blanked iff nibbles *i*..3 of `shadow` are all 0. Decimal points are unaffected.
- Decoder is standard hex 0–F, active-low, e.g. 0→7'h40, 1→7'h79, 8→7'h00, E→7'h06.

## Timing
- Reset values: `seg_n`=7'h7F, `dp_n`=1, `an_n`=4'hF, `frame_done`=0, `pending`=0, `staged`=`shadow`=0, `cnt`=0, `dig`=0, phase BLANK.
- Reset mid-frame: everything returns immediately (async) to the values above. Scanning restarts at digit 0 BLANK on the first edge after release.
- Outputs are registered. `an_n`/`seg_n`/`dp_n` reflect the `cnt`/`dig` of the previous cycle, so the pins lag the state by one cycle. `an_n` and `seg_n` change on the same edge.
- Frame = 4·`REFRESH_DIV` cycles.
- `wrt` to display latency: commit ≤ 4·`REFRESH_DIV` cycles after `wrt`. The value appears on pins from digit 0's DRIVE phase of the next frame.
- `pending` rises the cycle after `wrt` and falls the cycle after the committing boundary, coincident with the `frame_done` high cycle.

## Structure
- Package `seg_pkg`:
  - `SEG_BLANK`=7'h7F and `AN_OFF`=4'hF;
  - typedef `disp_t` = {logic [3:0] dp; logic [15:0] val};
  - phase enum {BLANK, DRIVE}.
- Sub-module `hex7_dec`: purely combinational 4-bit→7-bit active-low decoder, instantiated once, input muxed from `shadow` by `dig`.
- All sequencing, buffering and output registers live in `seg_scan_ctrl`.

## Test plan
Benches use `REFRESH_DIV`=8, `BLANK_CYC`=2.
- Reset, no `wrt`, run 2 frames:
  - `an_n` cycles E,D,B,7, each driven for 6 cycles after 2 cycles of F;
  - digit 0 shows 7'h40; digits 1–3 show 7'h7F (lz);
  - `frame_done` pulses every 32 cycles.
- `wrt` `val`=16'h12A8, `dp_in`=4'b0100 at cycle 5:
  - `pending`=1 until boundary at cycle 32, then 0;
  - next frame shows 8→7'h00, A→7'h08, 2→7'h24, 1→7'h79;
  - `dp_n`=0 only on digit 2.
- `wrt` 16'h0001 exactly on a boundary cycle:
  - that boundary commits the prior `staged`;
  - `pending` stays 1;
  - 16'h0001 commits at the next boundary.
- Two `wrt` (16'hAAAA then 16'h5555) in one frame: only 16'h5555 is displayed, with no frame showing 16'hAAAA.
- `BLANK_LZ`=0 with `val`=16'h0070: digits 3,2 show 7'h40, digit 1 shows 7'h78, digit 0 shows 7'h40.
- Assert `rst_n`=0 mid-DRIVE of digit 2 with `pending`=1:
  - outputs go to reset values asynchronously;
  - after release, scan resumes at digit 0 with `shadow`=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef struct packed {
      logic [3:0]  dp;
      logic [15:0] val;
   } disp_t;

   typedef enum logic {BLANK, DRIVE} phase_e;

   function automatic logic [3:0] nib_sel(input logic [15:0] v, input logic [1:0] d);
      logic [3:0] n;
      unique case (d)
         2'd0: n = v[3:0];
         2'd1: n = v[7:4];
         2'd2: n = v[11:8];
         2'd3: n = v[15:12];
      endcase
      return n;
   endfunction

   // A digit is a leading zero when it and every more-significant nibble are zero.
   function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] d);
      logic b;
      unique case (d)
         2'd0: b = 1'b0;
         2'd1: b = (v[15:4] == 12'h000);
         2'd2: b = (v[15:8] == 8'h00);
         2'd3: b = (v[15:12] == 4'h0);
      endcase
      return b;
   endfunction

endpackage

// File: rtl/hex7_dec.sv
// Combinational hex digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex7_dec (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      unique case (hex_i)
         4'h0: seg_n_o = 7'h40;
         4'h1: seg_n_o = 7'h79;
         4'h2: seg_n_o = 7'h24;
         4'h3: seg_n_o = 7'h30;
         4'h4: seg_n_o = 7'h19;
         4'h5: seg_n_o = 7'h12;
         4'h6: seg_n_o = 7'h02;
         4'h7: seg_n_o = 7'h78;
         4'h8: seg_n_o = 7'h00;
         4'h9: seg_n_o = 7'h10;
         4'hA: seg_n_o = 7'h08;
         4'hB: seg_n_o = 7'h03;
         4'hC: seg_n_o = 7'h46;
         4'hD: seg_n_o = 7'h21;
         4'hE: seg_n_o = 7'h06;
         4'hF: seg_n_o = 7'h0E;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned double buffering
// and leading-zero blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLANK_CYC   = 4,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] val,
   input  logic [3:0]  dp_in,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic        pending,
   output logic        frame_done
);

   localparam int unsigned      CntW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] LastCnt   = CntW'(REFRESH_DIV - 1);
   localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      dig_q, dig_d;
   phase_e          phase_q, phase_d;
   disp_t           staged_q, staged_d;
   disp_t           shadow_q, shadow_d;
   logic            pending_q, pending_d;
   logic            frame_done_q, frame_done_d;
   logic [6:0]      seg_n_q, seg_n_d;
   logic            dp_n_q, dp_n_d;
   logic [3:0]      an_n_q, an_n_d;

   logic       slot_end;
   logic       boundary;
   logic [3:0] cur_nib;
   logic [6:0] dec_seg_n;
   logic       cur_lz;

   assign slot_end = (cnt_q == LastCnt);
   assign boundary = slot_end && (dig_q == 2'd3);
   assign cur_nib  = nib_sel(shadow_q.val, dig_q);
   assign cur_lz   = BLANK_LZ && lz_blank(shadow_q.val, dig_q);

   hex7_dec u_hex7_dec (
      .hex_i   (cur_nib),
      .seg_n_o (dec_seg_n)
   );

   // Slot / digit / phase sequencing.
   always_comb begin
      cnt_d   = cnt_q + CntW'(1);
      dig_d   = dig_q;
      phase_d = phase_q;
      if (slot_end) begin
         cnt_d   = '0;
         dig_d   = dig_q + 2'd1;
         phase_d = BLANK;
      end else if (cnt_q == BlankLast) begin
         phase_d = DRIVE;
      end
   end

   // A write coinciding with the boundary lands in staging after the old value commits.
   always_comb begin
      staged_d     = staged_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      frame_done_d = boundary;
      if (boundary && pending_q) begin
         shadow_d  = staged_q;
         pending_d = 1'b0;
      end
      if (wrt) begin
         staged_d  = '{dp: dp_in, val: val};
         pending_d = 1'b1;
      end
   end

   always_comb begin
      an_n_d  = AN_OFF;
      seg_n_d = SEG_BLANK;
      dp_n_d  = 1'b1;
      if (phase_q == DRIVE) begin
         an_n_d  = ~(4'b0001 << dig_q);
         seg_n_d = cur_lz ? SEG_BLANK : dec_seg_n;
         dp_n_d  = ~shadow_q.dp[dig_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         dig_q        <= 2'd0;
         phase_q      <= BLANK;
         staged_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         seg_n_q      <= SEG_BLANK;
         dp_n_q       <= 1'b1;
         an_n_q       <= AN_OFF;
      end else begin
         cnt_q        <= cnt_d;
         dig_q        <= dig_d;
         phase_q      <= phase_d;
         staged_q     <= staged_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         an_n_q       <= an_n_d;
      end
   end

   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;
   assign an_n       = an_n_q;
   assign pending    = pending_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

   localparam int unsigned RefreshDiv = 8;
   localparam int unsigned BlankCyc   = 2;

   localparam logic [6:0] SegTab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wrt = 1'b0;
   logic [15:0] val = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        pending;
   logic        frame_done;

   logic        wrt_nz = 1'b0;
   logic [15:0] val_nz = 16'h0070;
   logic [3:0]  dp_nz = 4'h0;
   logic [6:0]  seg_n_nz;
   logic        dp_n_nz;
   logic [3:0]  an_n_nz;
   logic        pending_nz;
   logic        frame_done_nz;

   int n_checks = 0;
   int n_fail   = 0;
   int nz_wr_at = -1;
   bit nz_chk   = 1'b0;
   logic pend   = 1'b0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .REFRESH_DIV (RefreshDiv),
      .BLANK_CYC   (BlankCyc),
      .BLANK_LZ    (1'b1)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt        (wrt),
      .val        (val),
      .dp_in      (dp_in),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .pending    (pending),
      .frame_done (frame_done)
   );

   seg_scan_ctrl #(
      .REFRESH_DIV (RefreshDiv),
      .BLANK_CYC   (BlankCyc),
      .BLANK_LZ    (1'b0)
   ) u_dut_nz (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt        (wrt_nz),
      .val        (val_nz),
      .dp_in      (dp_nz),
      .seg_n      (seg_n_nz),
      .dp_n       (dp_n_nz),
      .an_n       (an_n_nz),
      .pending    (pending_nz),
      .frame_done (frame_done_nz)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit lz);
      logic [3:0] nib;
      nib = v[d*4 +: 4];
      if (lz && d > 0 && (v >> (4 * d)) == 16'h0) return 7'h7F;
      return SegTab[nib];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs n cycles of one frame window, expecting shown value sv/sdp, with up to two writes.
   task automatic scan_frame(input int fr, input logic [15:0] sv, input logic [3:0] sdp,
                             input int wo1, input logic [15:0] wv1, input logic [3:0] wd1,
                             input int wo2, input logic [15:0] wv2, input logic [3:0] wd2,
                             input int n);
      for (int i = 0; i < n; i++) begin
         int d;
         int c;
         logic w;
         logic [3:0] an_exp;
         logic [6:0] seg_exp;
         logic dp_exp;
         d = i / 8;
         c = i % 8;
         w = (i == wo1) || (i == wo2);
         wrt = w;
         if (i == wo1) begin
            val = wv1;
            dp_in = wd1;
         end else if (i == wo2) begin
            val = wv2;
            dp_in = wd2;
         end
         wrt_nz = (i == nz_wr_at);
         tick();
         wrt = 1'b0;
         wrt_nz = 1'b0;
         pend = w ? 1'b1 : ((i == 31) ? 1'b0 : pend);
         if (c < int'(BlankCyc)) begin
            an_exp  = 4'hF;
            seg_exp = 7'h7F;
            dp_exp  = 1'b1;
         end else begin
            an_exp  = ~(4'b0001 << d);
            seg_exp = exp_seg(sv, d, 1'b1);
            dp_exp  = ~sdp[d];
         end
         check_eq($sformatf("an f%0d i%0d", fr, i), an_n, an_exp);
         check_eq($sformatf("seg f%0d i%0d", fr, i), seg_n, seg_exp);
         check_eq($sformatf("dp f%0d i%0d", fr, i), dp_n, dp_exp);
         check_eq($sformatf("frame_done f%0d i%0d", fr, i), frame_done, (i == 31));
         check_eq($sformatf("pending f%0d i%0d", fr, i), pending, pend);
         if (nz_chk) begin
            seg_exp = (c < int'(BlankCyc)) ? 7'h7F : exp_seg(16'h0070, d, 1'b0);
            check_eq($sformatf("nz_seg f%0d i%0d", fr, i), seg_n_nz, seg_exp);
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst an", an_n, 4'hF);
      check_eq("rst seg", seg_n, 7'h7F);
      check_eq("rst dp", dp_n, 1'b1);
      check_eq("rst pending", pending, 1'b0);
      check_eq("rst frame_done", frame_done, 1'b0);
      rst_n = 1'b1;
      pend = 1'b0;

      // Idle frames: zero with leading digits blanked.
      scan_frame(0, 16'h0000, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 32);
      scan_frame(1, 16'h0000, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 32);
      nz_wr_at = 5;
      scan_frame(2, 16'h0000, 4'h0, 5, 16'h12A8, 4'b0100, -1, 16'h0, 4'h0, 32);
      nz_wr_at = -1;
      nz_chk = 1'b1;
      // Second write lands on the boundary: BEEF commits now, 0001 waits a frame.
      scan_frame(3, 16'h12A8, 4'b0100, 10, 16'hBEEF, 4'h0, 31, 16'h0001, 4'h0, 32);
      nz_chk = 1'b0;
      scan_frame(4, 16'hBEEF, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 32);
      scan_frame(5, 16'h0001, 4'h0, 3, 16'hAAAA, 4'h0, 20, 16'h5555, 4'h0, 32);
      // Stop mid-DRIVE of digit 2 with a write pending.
      scan_frame(6, 16'h5555, 4'h0, 2, 16'h1234, 4'hF, -1, 16'h0, 4'h0, 21);

      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async an", an_n, 4'hF);
      check_eq("async seg", seg_n, 7'h7F);
      check_eq("async dp", dp_n, 1'b1);
      check_eq("async pending", pending, 1'b0);
      check_eq("async frame_done", frame_done, 1'b0);
      check_eq("async nz seg", seg_n_nz, 7'h7F);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pend = 1'b0;
      scan_frame(7, 16'h0000, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 32);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
